stm32h7_pssi_8bus_tx: RTL

- FPGA-side PSSI transmitter. Streams 32-bit words, such as ADS8681 samples or status words, to the STM32H7 PSSI peripheral over an 8-bit bus, most-significant byte first.
- Generates the PSSI clock, data-enable (DE) and data, and buffers words in a small FIFO.
- Sits between the sample/command logic (valid/ready source) and the MCU pins. It is the transmit counterpart of the existing 8-bit/32-bit PSSI receive path.

---
 rtl/stm32h7_pssi_8bus_tx.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/stm32h7_pssi_8bus_tx.sv
`default_nettype none
// ============================================================================
// Module   : stm32h7_pssi_8bus_tx
// Purpose  : FPGA-side PSSI transmitter. Buffers 32-bit words in a small FIFO
//            and serialises them MSB-first onto an 8-bit PSSI bus, together
//            with a free-running PSSI clock and an active-low data enable.
//            Bus updates happen only on the falling PSSI clock edge, so data
//            and DE are stable around every rising edge, where the MCU samples.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_DIV      clk_i cycles per PSSI clock period (even, >= 2)
//   FIFO_AW      FIFO address width, depth = 2**FIFO_AW words
// Ports
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   s_data_i     word to transmit
//   s_valid_i    s_data_i valid
//   s_ready_o    FIFO can accept a word this cycle
//   test_mode_i  (PSSI_TX_TESTPAT_EN only) send incrementing counter words
//   pssi_clk_o   PSSI clock to the MCU, 50 % duty cycle
//   pssi_de_o    data enable, active low
//   pssi_data_o  PSSI data byte
//   fifo_level_o words currently stored in the FIFO
//   tx_busy_o    high while a word is being shifted out
// Optional feature macro: PSSI_TX_TESTPAT_EN
// ============================================================================
module stm32h7_pssi_8bus_tx #(
   parameter int CLK_DIV = 4,
   parameter int FIFO_AW = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [31:0]          s_data_i,
   input  logic                 s_valid_i,
   output logic                 s_ready_o,
`ifdef PSSI_TX_TESTPAT_EN
   input  logic                 test_mode_i,
`endif
   output logic                 pssi_clk_o,
   output logic                 pssi_de_o,
   output logic [7:0]           pssi_data_o,
   output logic [FIFO_AW:0]     fifo_level_o,
   output logic                 tx_busy_o
);

   localparam int c_DEPTH = 2 ** FIFO_AW;
   localparam int c_DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [c_DW-1:0]    c_DIV_LAST = c_DW'(CLK_DIV - 1);
   localparam logic [c_DW-1:0]    c_DIV_HALF = c_DW'(CLK_DIV / 2);
   localparam logic [c_DW-1:0]    c_DIV_ONE  = c_DW'(1);
   localparam logic [FIFO_AW-1:0] c_PTR_ONE  = FIFO_AW'(1);
   localparam logic [FIFO_AW:0]   c_LVL_ONE  = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW:0]   c_LVL_FULL = (FIFO_AW + 1)'(c_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_B3   = 3'd1,
      ST_B2   = 3'd2,
      ST_B1   = 3'd3,
      ST_B0   = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // PSSI clock divider
   // ------------------------------------------------------------------------
   logic [c_DW-1:0] r_div_cnt;
   logic [c_DW-1:0] w_div_nxt;
   logic            r_pssi_clk;
   logic            w_fall_tick;

   // The cycle whose closing edge wraps the counter is the one where the
   // registered PSSI clock drops from 1 to 0.
   assign w_fall_tick = (r_div_cnt == c_DIV_LAST);
   assign w_div_nxt   = w_fall_tick ? '0 : (r_div_cnt + c_DIV_ONE);

   // pssi_clk is registered from the next count, so it always equals
   // (r_div_cnt >= CLK_DIV/2) without a combinational output path.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_div_cnt  <= '0;
         r_pssi_clk <= 1'b0;
      end else begin
         r_div_cnt  <= w_div_nxt;
         r_pssi_clk <= (w_div_nxt >= c_DIV_HALF);
      end
   end

   // ------------------------------------------------------------------------
   // Word FIFO
   // ------------------------------------------------------------------------
   logic [31:0]        r_mem [c_DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW:0]   r_level;
   logic               w_wr;
   logic               w_pop;
   logic               w_empty;

   // Ready comes from the registered level only, so a pop in the same cycle
   // never opens a slot when full. Gating with the reset keeps it low while
   // reset is asserted and high right after release.
   assign s_ready_o = rst_n_i & (r_level < c_LVL_FULL);
   assign w_wr      = s_valid_i & s_ready_o;
   assign w_empty   = (r_level == '0);

   always_ff @(posedge clk_i) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= s_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + c_LVL_ONE;
            2'b01:   r_level <= r_level - c_LVL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Word source: FIFO head, or the test counter when enabled
   // ------------------------------------------------------------------------
   logic        w_load;
   logic        w_src_avail;
   logic [31:0] w_src_word;

`ifdef PSSI_TX_TESTPAT_EN
   logic [31:0] r_pat;

   // test_mode_i is only looked at when a new word is being chosen (w_load
   // happens in IDLE or at the B0 boundary), so words never mix sources.
   assign w_src_avail = test_mode_i | ~w_empty;
   assign w_src_word  = test_mode_i ? r_pat : r_mem[r_rd_ptr];
   assign w_pop       = w_load & ~test_mode_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_pat <= '0;
      end else if (w_load && test_mode_i) begin
         r_pat <= r_pat + 32'd1;
      end
   end
`else
   assign w_src_avail = ~w_empty;
   assign w_src_word  = r_mem[r_rd_ptr];
   assign w_pop       = w_load;
`endif

   // ------------------------------------------------------------------------
   // Byte serialiser FSM
   // ------------------------------------------------------------------------
   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_de;
   logic        w_de_nxt;
   logic [7:0]  r_data;
   logic [7:0]  w_data_nxt;
   // Only the three bytes still to be sent are kept; the top byte goes
   // straight from the source onto the bus when the word is loaded.
   logic [23:0] r_rest;
   logic [23:0] w_rest_nxt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
         r_de    <= 1'b1;
         r_data  <= '0;
         r_rest  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_de    <= w_de_nxt;
         r_data  <= w_data_nxt;
         r_rest  <= w_rest_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_de_nxt    = r_de;
      w_data_nxt  = r_data;
      w_rest_nxt  = r_rest;
      w_load      = 1'b0;
      if (w_fall_tick) begin
         case (r_state)
            ST_IDLE, ST_B0: begin
               if (w_src_avail) begin
                  w_load      = 1'b1;
                  w_data_nxt  = w_src_word[31:24];
                  w_rest_nxt  = w_src_word[23:0];
                  w_de_nxt    = 1'b0;
                  w_state_nxt = ST_B3;
               end else begin
                  // Data byte is left as-is; only DE marks the bus idle.
                  w_de_nxt    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_B3: begin
               w_data_nxt  = r_rest[23:16];
               w_state_nxt = ST_B2;
            end
            ST_B2: begin
               w_data_nxt  = r_rest[15:8];
               w_state_nxt = ST_B1;
            end
            ST_B1: begin
               w_data_nxt  = r_rest[7:0];
               w_state_nxt = ST_B0;
            end
            default: begin
               w_de_nxt    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign pssi_clk_o   = r_pssi_clk;
   assign pssi_de_o    = r_de;
   assign pssi_data_o  = r_data;
   assign fifo_level_o = r_level;
   assign tx_busy_o    = (r_state != ST_IDLE);

endmodule
`default_nettype wire
